// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-side control blocks.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W = 8;

  // Output stage occupancy: ST_LOADED means the stage holds a word for the FIFO.
  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
    return (ptr + 1 >= num_req) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: the search starts one past ptr_i and wraps.
module rr_pick
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = ptr_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(rr_next(32'(cand), NUM_REQ));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional saturating statistics counters when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = FIFO_DATA_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [CNT_W-1:0]          stat_words,
  output logic [CNT_W-1:0]          stat_stall,
`endif
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               out_valid;
  logic               stage_free;
  logic               transfer;
  logic [DATA_W-1:0]  win_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign out_valid    = (state_q == ST_LOADED);
  assign fifo_wr_en   = out_valid & ~fifo_full;
  assign fifo_wr_data = out_data_q;
  // A new word may load on the same edge the held word drains.
  assign stage_free   = ~out_valid | fifo_wr_en;
  assign req_ready    = (enable & stage_free & pick_valid) ? pick_gnt : '0;
  assign transfer     = |req_ready;
  assign busy         = out_valid | (|req_valid);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (transfer) state_d = ST_LOADED;
      end
      ST_LOADED: begin
        if (fifo_wr_en && !transfer) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (transfer) begin
      out_data_d = win_data;
      rr_ptr_d   = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_W-1:0] stat_words_q, stat_words_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q;
    stat_stall_d = stat_stall_q;
    if (fifo_wr_en && (stat_words_q != '1)) stat_words_d = stat_words_q + 1'b1;
    if (out_valid && fifo_full && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
